pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction fetch front end that owns the program counter, issues reads to the instruction cache over the read/busywait handshake, and presents `pc`, `pc+4` and the fetched instruction to the IF pipeline register. It sits between the instruction cache and the IF register and drives that register's `pc_in`, `pc_4_in`, `instruction_in` and `busywait` inputs. It takes branch/jump redirects from EX and stall requests from the hazard unit.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction value driven when no fetched instruction is held (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low. Asserting it clears state immediately; release is sampled on `clk`.
- `branch_jump_signal` in 1: redirect request, valid for one cycle.
- `branch_target` in 32: redirect address, valid with `branch_jump_signal`.
- `hold` in 1: when 1, downstream is not accepting the presented instruction.
- `imem_read` out 1: cache read request.
- `imem_address` out 32: cache read address.
- `imem_readdata` in 32: instruction word, valid in a cycle where `imem_read`=1 and `imem_busywait`=0.
- `imem_busywait` in 1: cache not ready.
- `pc_out` out 32: PC of the presented instruction.
- `pc_4_out` out 32: `pc_out`+4.
- `instruction_out` out 32: presented instruction.
- `busywait` out 1: 1 when no valid instruction is presented.
- `misaligned_out` out 1: present only when `FETCH_MISALIGN_CHECK_EN` is defined.

## Operation
- The state machine has three states: FETCH, DRAIN and PRESENT. The PC is held in a 32-bit register. All address arithmetic is modulo 2^32, so 0xFFFF_FFFC + 4 = 0x0000_0000.
- **FETCH:** `imem_read`=1 and `imem_address`=PC. The address stays stable while `imem_busywait`=1.
  - On an edge where `imem_busywait`=0: capture `imem_readdata` into `instruction_out` and go to PRESENT.
- **PRESENT:** `busywait`=0 and `imem_read`=0.
  - On an edge with `hold`=0: the instruction is consumed. Set PC ← PC+4 and go to FETCH.
  - On an edge with `hold`=1: all state and outputs are unchanged.
- **DRAIN:** `imem_read`=1 with the old address held stable.
  - On an edge with `imem_busywait`=0: discard the data, set PC ← pending target, and go to FETCH.
- **Redirect** (`branch_jump_signal`=1) has top priority over `hold` and over data return. Its effect depends on the state:
  - PRESENT, or FETCH with `imem_busywait`=0 in that cycle: PC ← aligned target, go to FETCH, and discard any returning data.
  - FETCH with `imem_busywait`=1: store the aligned target as pending and go to DRAIN. The cache request is never abandoned mid-handshake.
  - DRAIN: overwrite the pending target (last redirect wins).
- An aligned target is `{branch_target[31:2],2'b00}`.
- `busywait` = (state != PRESENT).
- Output relationships:
  - `pc_out` = PC.
  - `pc_4_out` = PC+4.
  - `instruction_out` = NOP_INSTR in every state except PRESENT.
- **Reset values:**
  - PC = RESET_PC; `pc_out` = RESET_PC; `pc_4_out` = RESET_PC+4.
  - `instruction_out` = NOP_INSTR; `busywait`=1; `imem_read`=0; `misaligned_out`=0.
  - State = FETCH. The first request is issued in the first cycle after reset release.
- Reset asserted mid-request abandons the request. The cache is required to tolerate `imem_read` dropping under reset.

## Timing
- Cache hit (`imem_busywait`=0 in the request cycle): the instruction is presented 1 cycle after the request.
- Best-case throughput is one instruction per 2 cycles (FETCH, then PRESENT).
- A cache miss of N busywait cycles adds N cycles.
- Redirect in PRESENT: the target request is issued in the next cycle.
- Redirect in FETCH during a miss: the remaining miss cycles are spent in DRAIN, then one FETCH for the target.
- All outputs except `imem_read`/`imem_address` come from registers. `imem_read`/`imem_address` are decoded from state and the PC register; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `FETCH_MISALIGN_CHECK_EN`.
- **Defined:** a redirect with `branch_target[1:0]`≠0 issues no cache request.
  - Next state is PRESENT with `pc_out`=raw target, `instruction_out`=NOP_INSTR and `misaligned_out`=1.
  - The block stays there regardless of `hold` until the next redirect. The trap redirect then clears `misaligned_out`.
  - If this redirect arrives during a cache miss, the block goes through DRAIN first.
- **Undefined:** `branch_target[1:0]` is ignored (forced to 00). The `misaligned_out` port and its logic do not exist.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (FETCH, DRAIN, PRESENT);
  - the NOP_INSTR constant;
  - the default RESET_PC.
- Single module. No sub-module is warranted; the PC incrementer is one adder expression.

## Test plan
- Reset low then released; cache always ready → requests at 0x0, 0x4, 0x8 on alternate cycles; `busywait` toggles 1/0; `pc_4_out`=`pc_out`+4.
- Miss with `imem_busywait`=1 for 3 cycles at 0x10 → `imem_address` stable at 0x10 for 4 cycles; instruction presented on the 5th cycle.
- `hold`=1 for 4 cycles in PRESENT → outputs frozen; PC advances to 0x14 only after `hold` drops.
- Redirect to 0x200 during a miss at 0x40 → address held at 0x40 until busywait drops; returned data is never presented; next request is to 0x200. A second redirect to 0x300 while in DRAIN → next request is to 0x300.
- PC=0xFFFF_FFFC consumed → next request at 0x0000_0000.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x102 → no request; `misaligned_out`=1, `pc_out`=0x102, `instruction_out`=0x0000_0013. A redirect to 0x80 then clears the flag. Without the macro: redirect to 0x102 fetches 0x100.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch front end
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, DRAIN, PRESENT} fetch_state_t;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC owner and I-cache requester feeding the IF register (optional FETCH_MISALIGN_CHECK_EN)
module pc_fetch_unit import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_jump_signal,
    input  logic [31:0] branch_target,
    input  logic        hold,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    output logic [31:0] pc_out,
    output logic [31:0] pc_4_out,
    output logic [31:0] instruction_out,
    output logic        busywait
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misaligned_out
`endif
);
    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, pc4_q, instr_q, instr_d, pend_q, pend_d, tgt;
    logic         active_q, jump, consume;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic         mis_q, mis_d;
    assign consume        = !hold && !mis_q;
    assign misaligned_out = mis_q;
`else
    assign consume = !hold;
`endif

    // requests start only once reset has been released for one edge
    assign imem_read       = active_q && (state_q != PRESENT);
    assign imem_address    = pc_q;
    assign pc_out          = pc_q;
    assign pc_4_out        = pc4_q;
    assign instruction_out = instr_q;
    assign busywait        = state_q != PRESENT;

    // state, PC and presented-instruction registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            pc4_q    <= RESET_PC + 32'd4;
            instr_q  <= NOP_INSTR;
            pend_q   <= RESET_PC;
            active_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc4_q    <= pc_d + 32'd4;
            instr_q  <= instr_d;
            pend_q   <= pend_d;
            active_q <= 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_q    <= mis_d;
`endif
        end
    end

    // next state: redirects win over hold and data return; a live miss is drained, never abandoned
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pend_d  = pend_q;
        jump    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        tgt = (state_q == DRAIN && !branch_jump_signal) ? pend_q : branch_target;
        case (state_q)
            FETCH: if (active_q) begin
                if (branch_jump_signal && imem_busywait) begin
                    pend_d  = branch_target;
                    state_d = DRAIN;
                end else if (branch_jump_signal) begin
                    jump = 1'b1;
                end else if (!imem_busywait) begin
                    instr_d = imem_readdata;
                    state_d = PRESENT;
                end
            end
            DRAIN: begin
                if (!imem_busywait) jump = 1'b1;
                else if (branch_jump_signal) pend_d = branch_target;
            end
            PRESENT: begin
                if (branch_jump_signal) begin
                    jump = 1'b1;
                end else if (consume) begin
                    pc_d    = pc_q + 32'd4;
                    instr_d = NOP_INSTR;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        if (jump) begin
            instr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis_d   = tgt[1:0] != 2'b00;
            state_d = mis_d ? PRESENT : FETCH;
            pc_d    = mis_d ? tgt : (tgt & ~32'd3);
`else
            state_d = FETCH;
            pc_d    = tgt & ~32'd3;
`endif
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plus randomized checks of pc_fetch_unit against a transaction-level model
module tb_pc_fetch_unit;
    logic        clk = 1'b0, reset = 1'b0;
    logic        branch_jump_signal = 1'b0, hold = 1'b0, imem_busywait = 1'b0;
    logic [31:0] branch_target = '0, imem_readdata = '0;
    logic        imem_read, busywait;
    logic [31:0] imem_address, pc_out, pc_4_out, instruction_out;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misaligned_out;
`endif
    int checks = 0, errors = 0;

    // model: which phase of the fetch transaction the front end is in
    bit          m_started, m_pres, m_drain, m_mis;
    logic [31:0] m_pc, m_pend, m_instr;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset),
        .branch_jump_signal(branch_jump_signal), .branch_target(branch_target), .hold(hold),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_readdata(imem_readdata), .imem_busywait(imem_busywait),
        .pc_out(pc_out), .pc_4_out(pc_4_out), .instruction_out(instruction_out),
        .busywait(busywait)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .misaligned_out(misaligned_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_started = 0; m_pres = 0; m_drain = 0; m_mis = 0;
        m_pc = 32'h0; m_pend = 32'h0; m_instr = 32'h13;
    endtask

    task automatic m_jump(input logic [31:0] t);
        m_drain = 0;
        m_instr = 32'h13;
        m_mis   = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (t % 4 != 0) begin
            m_pc = t; m_pres = 1; m_mis = 1;
            return;
        end
`endif
        m_pc   = t - (t % 4);
        m_pres = 0;
    endtask

    task automatic m_update(input bit b, input logic [31:0] t, input bit h, input bit bw, input logic [31:0] rd);
        if (!m_started) m_started = 1;
        else if (m_pres) begin
            if (b) m_jump(t);
            else if (!h && !m_mis) begin m_pc = m_pc + 4; m_pres = 0; m_instr = 32'h13; end
        end else if (m_drain) begin
            if (!bw) m_jump(b ? t : m_pend);
            else if (b) m_pend = t;
        end else if (b && bw) begin m_pend = t; m_drain = 1; end
        else if (b) m_jump(t);
        else if (!bw) begin m_instr = rd; m_pres = 1; end
    endtask

    task automatic compare_all();
        check("imem_read", {31'b0, imem_read}, {31'b0, m_started && !m_pres});
        check("imem_address", imem_address, m_pc);
        check("pc_out", pc_out, m_pc);
        check("pc_4_out", pc_4_out, m_pc + 32'd4);
        check("instruction_out", instruction_out, m_instr);
        check("busywait", {31'b0, busywait}, {31'b0, !m_pres});
`ifdef FETCH_MISALIGN_CHECK_EN
        check("misaligned_out", {31'b0, misaligned_out}, {31'b0, m_mis});
`endif
    endtask

    // one cycle: drive at negedge, model the edge, compare at the following negedge
    task automatic step(input bit b, input logic [31:0] t, input bit h, input bit bw, input logic [31:0] rd);
        branch_jump_signal = b; branch_target = t; hold = h; imem_busywait = bw; imem_readdata = rd;
        @(posedge clk);
        #1 m_update(b, t, h, bw, rd);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_pc_4_out", pc_4_out, 32'h4);
        check("rst_instr", instruction_out, 32'h13);
        check("rst_busywait", {31'b0, busywait}, 32'h1);
        check("rst_imem_read", {31'b0, imem_read}, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 0, 32'h1000 + i);
            if (i == 4) check("seq_addr_8", imem_address, 32'h8);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 32'hBAD0_0000 + i);
            check("miss_addr_stable", imem_address, 32'h10);
        end
        step(0, 0, 0, 0, 32'h1234_5678);
        check("miss_present", instruction_out, 32'h1234_5678);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 32'h0);
        check("hold_pc", pc_out, 32'h10);
        step(0, 0, 0, 0, 32'h0);
        check("after_hold_addr", imem_address, 32'h14);
        step(1, 32'h40, 0, 0, 32'h0);
        step(1, 32'h200, 0, 1, 32'h0);
        check("drain_addr", imem_address, 32'h40);
        step(0, 0, 0, 1, 32'h0);
        step(1, 32'h300, 0, 1, 32'h0);
        step(0, 0, 0, 0, 32'hDEAD_BEEF);
        check("drain_target_addr", imem_address, 32'h300);
        check("drain_data_dropped", instruction_out, 32'h13);
        step(1, 32'hFFFF_FFFC, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h5);
        check("wrap_pc4", pc_4_out, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        check("wrap_addr", imem_address, 32'h0);
        step(1, 32'h102, 0, 0, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_flag", {31'b0, misaligned_out}, 32'h1);
        check("mis_pc", pc_out, 32'h102);
        check("mis_instr", instruction_out, 32'h13);
        check("mis_no_read", {31'b0, imem_read}, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(1, 32'h80, 0, 0, 32'h0);
        check("mis_cleared", {31'b0, misaligned_out}, 32'h0);
        check("trap_addr", imem_address, 32'h80);
`else
        check("align_addr", imem_address, 32'h100);
`endif
        for (int i = 0; i < 600; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            step($urandom_range(7) == 0, t, $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom);
        end
        step(0, 0, 0, 1, 32'h0);
        reset = 1'b0;
        #1;
        m_reset();
        check("midrst_read", {31'b0, imem_read}, 32'h0);
        check("midrst_pc", pc_out, 32'h0);
        check("midrst_instr", instruction_out, 32'h13);
        reset = 1'b1;
        for (int i = 0; i < 50; i++)
            step($urandom_range(7) == 0, $urandom & ~32'd3, $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
